// File: rtl/accum_stack_if.sv
// Bus between the datapath and the accumulator: requests in, registered state out.
interface accum_stack_if #(parameter int WIDTH = 16);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             valid_din;
    logic [WIDTH-1:0] din;
    logic [2:0]       op;
    logic             push;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] dout;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output load, load_data, valid_din, din, op, push, pop, clear_err,
        input  dout, flag_z, flag_n, flag_c, flag_v, full, empty, err
    );

    modport slave (
        input  load, load_data, valid_din, din, op, push, pop, clear_err,
        output dout, flag_z, flag_n, flag_c, flag_v, full, empty, err
    );
endinterface

// File: rtl/accum_stack.sv
// Working accumulator with in-place ALU, status flags and a LIFO save/restore
// stack. Priority per cycle: load > pop (incl. swap) > ALU op; push rides along.
module accum_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    accum_stack_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_SAR  = 3'b111
    } op_e;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             z_q, n_q, c_q, v_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, err_q;

    logic [WIDTH-1:0] stk [DEPTH];
    logic             stk_we;
    logic [AW-1:0]    stk_wa;
    logic [AW-1:0]    top_idx;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;
    logic             acc_we, cv_clr, err_ev;

    assign top_idx = AW'(count_q - CW'(1));

    // ALU works on the pre-update accumulator; result only used when valid_din wins.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        case (op_e'(bus.op))
            OP_PASS: alu_res = bus.din;
            OP_ADD: begin
                sum     = {1'b0, acc_q} + {1'b0, bus.din};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (acc_q[MSB] == bus.din[MSB]) && (alu_res[MSB] != acc_q[MSB]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                sum     = {1'b0, acc_q} - {1'b0, bus.din};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (acc_q[MSB] != bus.din[MSB]) && (alu_res[MSB] != acc_q[MSB]);
            end
            OP_AND:  alu_res = acc_q & bus.din;
            OP_OR:   alu_res = acc_q | bus.din;
            OP_XOR:  alu_res = acc_q ^ bus.din;
            OP_SHL: begin
                alu_res = {acc_q[MSB-1:0], 1'b0};
                alu_c   = acc_q[MSB];
            end
            OP_SAR: begin
                alu_res = {acc_q[MSB], acc_q[MSB:1]};
                alu_c   = acc_q[0];
            end
            default: alu_res = bus.din;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        acc_we  = 1'b0;
        cv_clr  = 1'b0;
        count_d = count_q;
        stk_we  = 1'b0;
        stk_wa  = top_idx;
        err_ev  = 1'b0;
        if (bus.load) begin
            acc_d  = bus.load_data;
            acc_we = 1'b1;
            cv_clr = 1'b1;
        end else if (bus.pop) begin
            if (empty_q) begin
                err_ev = 1'b1;
            end else begin
                acc_d  = stk[top_idx];
                acc_we = 1'b1;
                cv_clr = 1'b1;
                if (bus.push) begin
                    // swap: old accumulator replaces the top, depth unchanged
                    stk_we = 1'b1;
                    stk_wa = top_idx;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
        end else begin
            if (bus.push) begin
                if (full_q) begin
                    err_ev = 1'b1;
                end else begin
                    stk_we  = 1'b1;
                    stk_wa  = AW'(count_q);
                    count_d = count_q + CW'(1);
                end
            end
            if (bus.valid_din) begin
                acc_d  = alu_res;
                acc_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            if (acc_we) begin
                acc_q <= acc_d;
                z_q   <= (acc_d == '0);
                n_q   <= acc_d[MSB];
                c_q   <= cv_clr ? 1'b0 : alu_c;
                v_q   <= cv_clr ? 1'b0 : alu_v;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            err_q   <= err_ev | (err_q & ~bus.clear_err);
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (stk_we) stk[stk_wa] <= acc_q;
    end

    assign bus.dout   = acc_q;
    assign bus.flag_z = z_q;
    assign bus.flag_n = n_q;
    assign bus.flag_c = c_q;
    assign bus.flag_v = v_q;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.err    = err_q;
endmodule
